// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_pkg: shared state encoding and widths for the game session and  |
// | countdown timer blocks.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package game_pkg;

    localparam int c_score_w_def = 8;
    localparam int c_time_w      = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2,
        ST_OVER = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/game_session_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: up-counter that sticks at all-ones instead of wrapping. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_nxt
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    always_comb begin
        o_count_nxt = r_count;
        if (i_clr)
            o_count_nxt = '0;
        else if (i_inc && (r_count != c_max))
            o_count_nxt = r_count + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else
            r_count <= o_count_nxt;
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/game_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_session_ctrl: sequences a round (IDLE/ARM/PLAY/OVER), counts     |
// | hits and keeps a session high score (GAME_SESSION_HIGHSCORE_EN).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W    = c_score_w_def,
    parameter int WARN_SEC   = 5,
    parameter int HOLD_TICKS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_btn,
    input  logic                abort_btn,
    input  logic                hit,
    input  logic                ms100,
    input  logic [c_time_w-1:0] time_left,
    input  logic                timer_stop,
    output logic                timer_en,
    output logic                playing,
    output logic                game_over,
    output logic                warn,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  high_score,
    output logic                new_record
);

    localparam int c_hold_w = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [c_time_w-1:0] c_warn_sec = c_time_w'(WARN_SEC);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                w_hold_done;
    logic                w_start_round;
    logic                w_end_round;
    logic [SCORE_W-1:0]  w_score_nxt;

    assign w_start_round = (r_state == ST_IDLE) && start_btn;
    // Abort wins over a simultaneous stop, so only a clean stop ends the round.
    assign w_end_round   = (r_state == ST_PLAY) && !abort_btn && timer_stop;
    assign w_hold_done   = (HOLD_TICKS == 0) ||
                           (ms100 && ((32'(r_hold_cnt) + 32'd1) >= 32'(HOLD_TICKS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_btn)  w_state_nxt = ST_ARM;
            ST_ARM:                  w_state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (abort_btn)       w_state_nxt = ST_IDLE;
                else if (timer_stop) w_state_nxt = ST_OVER;
            end
            ST_OVER: if (w_hold_done) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Held at zero outside OVER, which gives the clear-on-entry for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hold_cnt <= '0;
        else if (r_state != ST_OVER)
            r_hold_cnt <= '0;
        else if (ms100)
            r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
    end

    sat_counter #(
        .WIDTH (SCORE_W)
    ) u_score (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start_round),
        .i_inc       ((r_state == ST_PLAY) && hit),
        .o_count     (score),
        .o_count_nxt (w_score_nxt)
    );

    assign timer_en  = (r_state == ST_ARM) || (r_state == ST_PLAY);
    assign playing   = timer_en;
    assign game_over = (r_state == ST_OVER);
    assign warn      = (r_state == ST_PLAY) && (time_left <= c_warn_sec);

`ifdef GAME_SESSION_HIGHSCORE_EN
    logic [SCORE_W-1:0] r_high_score;
    logic               r_new_record;

    // Compare against the next score so a hit coincident with stop counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_high_score <= '0;
            r_new_record <= 1'b0;
        end else if (w_start_round) begin
            r_new_record <= 1'b0;
        end else if (w_end_round && (w_score_nxt > r_high_score)) begin
            r_high_score <= w_score_nxt;
            r_new_record <= 1'b1;
        end
    end

    assign high_score = r_high_score;
    assign new_record = r_new_record;
`else
    logic w_unused;
    assign w_unused   = ^{w_score_nxt, w_end_round};
    assign high_score = '0;
    assign new_record = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_session_ctrl: directed bench for game_session_ctrl.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_game_session_ctrl;

`ifdef GAME_SESSION_HIGHSCORE_EN
    localparam bit c_hs = 1'b1;
`else
    localparam bit c_hs = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0, abort_btn = 1'b0, hit = 1'b0, ms100 = 1'b0;
    logic       timer_stop = 1'b0;
    logic [6:0] time_left = 7'd30;
    logic       timer_en, playing, game_over, warn, new_record;
    logic [3:0] score, high_score;

    // Second instance exercising the zero-length hold.
    logic       s0_start = 1'b0, s0_stop = 1'b0, s0_zero = 1'b0;
    logic       t0_en, p0, go0, w0, nr0;
    logic [7:0] sc0, hs0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_session_ctrl #(.SCORE_W(4), .WARN_SEC(5), .HOLD_TICKS(20)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .abort_btn(abort_btn),
        .hit(hit), .ms100(ms100), .time_left(time_left), .timer_stop(timer_stop),
        .timer_en(timer_en), .playing(playing), .game_over(game_over), .warn(warn),
        .score(score), .high_score(high_score), .new_record(new_record)
    );

    game_session_ctrl #(.HOLD_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .start_btn(s0_start), .abort_btn(s0_zero),
        .hit(s0_zero), .ms100(s0_zero), .time_left(time_left), .timer_stop(s0_stop),
        .timer_en(t0_en), .playing(p0), .game_over(go0), .warn(w0),
        .score(sc0), .high_score(hs0), .new_record(nr0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1; step(); hit = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms100 = 1'b1; step(); ms100 = 1'b0;
        end
    endtask

    task automatic start_round();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        step();
    endtask

    task automatic stop_round();
        timer_stop = 1'b1; step(); timer_stop = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        chk("rst_timer_en", timer_en, 0);
        chk("rst_playing", playing, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_warn", warn, 0);
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_record", new_record, 0);

        // Round 1: three hits then expiry.
        start_btn = 1'b1; step(); start_btn = 1'b0;
        chk("arm_timer_en", timer_en, 1);
        chk("arm_playing", playing, 1);
        chk("arm_game_over", game_over, 0);
        step();
        hits(3);
        chk("r1_score_play", score, 3);
        stop_round();
        chk("r1_game_over", game_over, 1);
        chk("r1_timer_en", timer_en, 0);
        chk("r1_score", score, 3);
        chk("r1_high", high_score, c_hs ? 3 : 0);
        chk("r1_record", new_record, c_hs ? 1 : 0);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        chk("over_start_ignored", playing, 0);
        ticks(19);
        chk("hold_19", game_over, 1);
        ticks(1);
        chk("hold_20", game_over, 0);
        chk("idle_playing", playing, 0);
        chk("idle_score_kept", score, 3);

        // Round 2 lower, round 3 tie.
        start_round();
        hits(2);
        stop_round();
        chk("r2_score", score, 2);
        chk("r2_high", high_score, c_hs ? 3 : 0);
        chk("r2_record", new_record, 0);
        ticks(20);
        start_round();
        hits(3);
        stop_round();
        chk("r3_high", high_score, c_hs ? 3 : 0);
        chk("r3_record", new_record, 0);
        ticks(20);

        // Round 4: hit coincident with stop is counted.
        start_round();
        hits(4);
        hit = 1'b1; timer_stop = 1'b1; step(); hit = 1'b0; timer_stop = 1'b0;
        chk("r4_score", score, 5);
        chk("r4_high", high_score, c_hs ? 5 : 0);
        chk("r4_record", new_record, c_hs ? 1 : 0);
        chk("r4_game_over", game_over, 1);
        ticks(20);

        // Round 5: abort at score 9, trailing stop ignored.
        start_round();
        chk("r5_score_cleared", score, 0);
        chk("r5_record_cleared", new_record, 0);
        hits(9);
        abort_btn = 1'b1; step(); abort_btn = 1'b0;
        chk("abort_timer_en", timer_en, 0);
        chk("abort_game_over", game_over, 0);
        chk("abort_score", score, 9);
        chk("abort_high", high_score, c_hs ? 5 : 0);
        stop_round();
        chk("stray_stop_go", game_over, 0);
        chk("stray_stop_play", playing, 0);

        // Abort and stop together: abort wins.
        start_round();
        abort_btn = 1'b1; timer_stop = 1'b1; step(); abort_btn = 1'b0; timer_stop = 1'b0;
        chk("abort_vs_stop_go", game_over, 0);
        chk("abort_vs_stop_play", playing, 0);

        // Round 6: hit in ARM ignored, saturation, warn threshold.
        time_left = 7'd5; #1;
        chk("warn_idle", warn, 0);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        hit = 1'b1; step(); hit = 1'b0;
        chk("arm_hit_ignored", score, 0);
        chk("warn_at_5", warn, 1);
        time_left = 7'd6; #1;
        chk("warn_at_6", warn, 0);
        hits(20);
        chk("sat_score", score, 15);
        stop_round();
        chk("r6_high", high_score, c_hs ? 15 : 0);
        chk("warn_over", warn, 0);

        // Asynchronous reset in OVER.
        #2 rst = 1'b1; #1;
        chk("arst_game_over", game_over, 0);
        chk("arst_score", score, 0);
        chk("arst_high", high_score, 0);
        #1 rst = 1'b0;
        step();

        // HOLD_TICKS = 0: OVER lasts a single cycle.
        s0_start = 1'b1; step(); s0_start = 1'b0;
        step();
        chk("h0_playing", p0, 1);
        s0_stop = 1'b1; step(); s0_stop = 1'b0;
        chk("h0_over", go0, 1);
        step();
        chk("h0_over_done", go0, 0);
        chk("h0_idle", p0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
